// File: rtl/bneck_pkg.sv
// Shared encodings for the bottleneck layer: func commands, sequencer
// states and load-phase lengths derived from regfile address widths.
package bneck_pkg;

    localparam logic [1:0] FUNC_IDLE      = 2'b00;
    localparam logic [1:0] FUNC_LOAD_WGHT = 2'b01;
    localparam logic [1:0] FUNC_LOAD_IACT = 2'b10;
    localparam logic [1:0] FUNC_COMPUTE   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_W,
        ST_WAIT_I,
        ST_LD_I,
        ST_COMP,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

    localparam int DEF_WEIGHTS_ADDR_BITWIDTH = 4;
    localparam int DEF_IACTS_ADDR_BITWIDTH   = 4;
    localparam int DEF_COMPUTE_CYC           = 4;
    localparam int DEF_COUNT_BITWIDTH        = 16;

    // A load phase streams one regfile entry per cycle.
    function automatic int load_cyc(input int addr_bits);
        return 1 << addr_bits;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int WGHT_LOAD_CYC = load_cyc(DEF_WEIGHTS_ADDR_BITWIDTH);
    localparam int IACT_LOAD_CYC = load_cyc(DEF_IACTS_ADDR_BITWIDTH);

endpackage

// File: rtl/bneck_phase_cnt.sv
// Phase length counter: load with length-1, count down, tc at zero.
// Clear has priority so an aborted phase leaves the counter at zero.
module bneck_phase_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] val_i,
    input  logic             dec_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/bneck_layer_sequencer.sv
// Phase sequencer for the bottleneck layer (weights, iacts, compute, drain).
// Define BNECK_SEQ_PERF_EN to add the perf_stall_cnt output.
module bneck_layer_sequencer
    import bneck_pkg::*;
#(
    parameter int WEIGHTS_ADDR_BITWIDTH = DEF_WEIGHTS_ADDR_BITWIDTH,
    parameter int IACTS_ADDR_BITWIDTH   = DEF_IACTS_ADDR_BITWIDTH,
    parameter int COMPUTE_CYC           = DEF_COMPUTE_CYC,
    parameter int COUNT_BITWIDTH        = DEF_COUNT_BITWIDTH
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic                      start,
    input  logic                      abort,
    input  logic [COUNT_BITWIDTH-1:0] cfg_num_vec,
    input  logic                      cfg_reload_w,
    input  logic                      iact_valid,
    output logic                      iact_ready,
    output logic [1:0]                func,
    output logic                      oacts_valid,
    input  logic                      oacts_ready,
    output logic                      busy,
    output logic                      done,
    output logic [COUNT_BITWIDTH-1:0] vec_cnt
`ifdef BNECK_SEQ_PERF_EN
    ,
    output logic [31:0]               perf_stall_cnt
`endif
);

    localparam int W_CYC   = load_cyc(WEIGHTS_ADDR_BITWIDTH);
    localparam int I_CYC   = load_cyc(IACTS_ADDR_BITWIDTH);
    localparam int PH_MAX  = max3(W_CYC, I_CYC, COMPUTE_CYC);
    localparam int PH_BITS = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    seq_state_e                state_q;
    logic [1:0]                func_q;
    logic                      iact_ready_q;
    logic                      oacts_valid_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      wght_valid_q;
    logic [COUNT_BITWIDTH-1:0] num_vec_q;
    logic [COUNT_BITWIDTH-1:0] vec_cnt_q;

    logic               ph_clr;
    logic               ph_load;
    logic [PH_BITS-1:0] ph_val;
    logic               ph_dec;
    logic               ph_tc;

    logic                      abort_act;
    logic                      start_go;
    logic                      need_w;
    logic                      iact_hs;
    logic                      oacts_hs;
    logic [COUNT_BITWIDTH-1:0] vec_inc;
    logic                      last_vec;

    assign abort_act = abort && (state_q != ST_IDLE);
    assign start_go  = start && !abort && (state_q == ST_IDLE);
    assign need_w    = cfg_reload_w || !wght_valid_q;
    assign iact_hs   = iact_valid && iact_ready_q;
    assign oacts_hs  = oacts_valid_q && oacts_ready;
    assign vec_inc   = vec_cnt_q + COUNT_BITWIDTH'(1);
    assign last_vec  = (vec_inc == num_vec_q);

    // Counter is loaded on entry to each timed phase.
    always_comb begin
        ph_clr  = 1'b0;
        ph_load = 1'b0;
        ph_val  = '0;
        ph_dec  = 1'b0;
        if (abort_act) begin
            ph_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_go && (cfg_num_vec != '0) && need_w) begin
                        ph_load = 1'b1;
                        ph_val  = PH_BITS'(W_CYC - 1);
                    end
                end
                ST_WAIT_I: begin
                    if (iact_hs) begin
                        ph_load = 1'b1;
                        ph_val  = PH_BITS'(I_CYC - 1);
                    end
                end
                ST_LD_I: begin
                    if (ph_tc) begin
                        ph_load = 1'b1;
                        ph_val  = PH_BITS'(COMPUTE_CYC - 1);
                    end else begin
                        ph_dec = 1'b1;
                    end
                end
                ST_LD_W, ST_COMP: ph_dec = 1'b1;
                default: ;
            endcase
        end
    end

    bneck_phase_cnt #(
        .WIDTH (PH_BITS)
    ) u_phase_cnt (
        .clk    (clk),
        .rstN   (rstN),
        .clr_i  (ph_clr),
        .load_i (ph_load),
        .val_i  (ph_val),
        .dec_i  (ph_dec),
        .tc_o   (ph_tc)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q       <= ST_IDLE;
            func_q        <= FUNC_IDLE;
            iact_ready_q  <= 1'b0;
            oacts_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            wght_valid_q  <= 1'b0;
            num_vec_q     <= '0;
            vec_cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_act) begin
                state_q       <= ST_IDLE;
                func_q        <= FUNC_IDLE;
                iact_ready_q  <= 1'b0;
                oacts_valid_q <= 1'b0;
                busy_q        <= 1'b0;
                if (state_q == ST_LD_W) begin
                    wght_valid_q <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start_go) begin
                            num_vec_q <= cfg_num_vec;
                            vec_cnt_q <= '0;
                            busy_q    <= 1'b1;
                            if (cfg_num_vec == '0) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else if (need_w) begin
                                state_q <= ST_LD_W;
                                func_q  <= FUNC_LOAD_WGHT;
                            end else begin
                                state_q      <= ST_WAIT_I;
                                iact_ready_q <= 1'b1;
                            end
                        end
                    end
                    ST_LD_W: begin
                        if (ph_tc) begin
                            wght_valid_q <= 1'b1;
                            state_q      <= ST_WAIT_I;
                            func_q       <= FUNC_IDLE;
                            iact_ready_q <= 1'b1;
                        end
                    end
                    ST_WAIT_I: begin
                        if (iact_hs) begin
                            state_q      <= ST_LD_I;
                            func_q       <= FUNC_LOAD_IACT;
                            iact_ready_q <= 1'b0;
                        end
                    end
                    ST_LD_I: begin
                        if (ph_tc) begin
                            state_q <= ST_COMP;
                            func_q  <= FUNC_COMPUTE;
                        end
                    end
                    ST_COMP: begin
                        if (ph_tc) begin
                            state_q       <= ST_DRAIN;
                            func_q        <= FUNC_IDLE;
                            oacts_valid_q <= 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        if (oacts_hs) begin
                            oacts_valid_q <= 1'b0;
                            vec_cnt_q     <= vec_inc;
                            if (last_vec) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q      <= ST_WAIT_I;
                                iact_ready_q <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign func        = func_q;
    assign iact_ready  = iact_ready_q;
    assign oacts_valid = oacts_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign vec_cnt     = vec_cnt_q;

`ifdef BNECK_SEQ_PERF_EN
    logic [31:0] perf_q;
    logic        stall;

    assign stall = busy_q &&
                   (((state_q == ST_WAIT_I) && !iact_valid) ||
                    ((state_q == ST_DRAIN) && !oacts_ready));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            perf_q <= '0;
        end else if (start_go) begin
            perf_q <= '0;
        end else if (stall && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_bneck_layer_sequencer.sv
// Scoreboard bench for bneck_layer_sequencer: run timing is predicted from
// phase lengths and stall delays, then checked by a negedge monitor.
module tb_bneck_layer_sequencer;
    import bneck_pkg::*;

    localparam int W = WGHT_LOAD_CYC;
    localparam int I = IACT_LOAD_CYC;
    localparam int C = DEF_COMPUTE_CYC;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_num_vec = '0;
    logic        cfg_reload_w = 1'b0;
    logic        iact_valid = 1'b0;
    logic        iact_ready;
    logic [1:0]  func;
    logic        oacts_valid;
    logic        oacts_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] vec_cnt;
`ifdef BNECK_SEQ_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    bneck_layer_sequencer dut (
        .clk          (clk),
        .rstN         (rstN),
        .start        (start),
        .abort        (abort),
        .cfg_num_vec  (cfg_num_vec),
        .cfg_reload_w (cfg_reload_w),
        .iact_valid   (iact_valid),
        .iact_ready   (iact_ready),
        .func         (func),
        .oacts_valid  (oacts_valid),
        .oacts_ready  (oacts_ready),
        .busy         (busy),
        .done         (done),
        .vec_cnt      (vec_cnt)
`ifdef BNECK_SEQ_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int v;
    } o_exp_t;

    typedef struct {
        int c;
        int v;
        int nw;
        int ni;
        int nc;
        int st;
    } d_exp_t;

    o_exp_t q_o[$];
    d_exp_t q_d[$];
    int     n_tests = 0;
    int     n_fail = 0;
    int     dly_i[8];
    int     dly_o[8];
    bit     wv_m = 1'b0;
    int     cnt_w = 0;
    int     cnt_i = 0;
    int     cnt_c = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: phase cycle counts, oacts handshakes, done pulses.
    logic   prev_ov = 1'b0;
    logic   prev_hs = 1'b0;
    o_exp_t eo_m;
    d_exp_t ed_m;
    always @(negedge clk) begin
        if (rstN) begin
            if (func == FUNC_LOAD_WGHT) cnt_w++;
            if (func == FUNC_LOAD_IACT) cnt_i++;
            if (func == FUNC_COMPUTE) cnt_c++;
            if (prev_ov && !prev_hs) chk("oacts_valid_stable", oacts_valid, 1);
            if (oacts_valid && oacts_ready) begin
                if (q_o.size() == 0) begin
                    chk("unexpected_oacts_hs", 1, 0);
                end else begin
                    eo_m = q_o.pop_front();
                    chk("oacts_hs_cycle", cyc, eo_m.c);
                    chk("oacts_hs_vec_cnt", vec_cnt, eo_m.v);
                end
            end
            if (done) begin
                if (q_d.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    ed_m = q_d.pop_front();
                    chk("done_cycle", cyc, ed_m.c);
                    chk("done_vec_cnt", vec_cnt, ed_m.v);
                    chk("done_busy", busy, 1);
                    chk("wload_cycles", cnt_w, ed_m.nw);
                    chk("iload_cycles", cnt_i, ed_m.ni);
                    chk("compute_cycles", cnt_c, ed_m.nc);
`ifdef BNECK_SEQ_PERF_EN
                    chk("perf_stall_cnt", perf_stall_cnt, ed_m.st);
`endif
                end
                cnt_w = 0;
                cnt_i = 0;
                cnt_c = 0;
            end
            prev_ov = oacts_valid;
            prev_hs = oacts_valid && oacts_ready;
        end else begin
            prev_ov = 1'b0;
            prev_hs = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 3000) begin
            step();
            k++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 3000) begin
            step();
            k++;
        end
        if (busy) chk("idle_timeout", 0, 1);
        step();
    endtask

    task automatic drive_iact(input int n);
        for (int v = 0; v < n; v++) begin
            int k = 0;
            while (!iact_ready && k < 3000) begin
                step();
                k++;
            end
            if (!iact_ready) begin
                chk("iact_ready_timeout", 0, 1);
                return;
            end
            repeat (dly_i[v]) step();
            iact_valid = 1'b1;
            step();
            iact_valid = 1'b0;
        end
    endtask

    task automatic drive_oacts(input int n);
        for (int v = 0; v < n; v++) begin
            int k = 0;
            while (!oacts_valid && k < 3000) begin
                step();
                k++;
            end
            if (!oacts_valid) begin
                chk("oacts_valid_timeout", 0, 1);
                return;
            end
            repeat (dly_o[v]) step();
            oacts_ready = 1'b1;
            step();
            oacts_ready = 1'b0;
        end
    endtask

    // Predict the run from phase lengths plus stalls, then drive it.
    task automatic do_run(input int n, input bit rl, input bit hold);
        int     t0;
        int     t;
        int     st;
        bit     need;
        o_exp_t eo;
        d_exp_t ed;
        need = rl || !wv_m;
        st = 0;
        cfg_num_vec = 16'(n);
        cfg_reload_w = rl;
        start = 1'b1;
        t0 = cyc;
        ed.nw = 0;
        if (n == 0) begin
            ed.c = t0 + 1;
        end else begin
            ed.nw = need ? W : 0;
            t = t0 + ed.nw;
            for (int v = 0; v < n; v++) begin
                t += I + C + 2 + dly_i[v] + dly_o[v];
                st += dly_i[v] + dly_o[v];
                eo.c = t;
                eo.v = v;
                q_o.push_back(eo);
            end
            ed.c = t + 1;
            if (need) wv_m = 1'b1;
        end
        ed.v = n;
        ed.ni = n * I;
        ed.nc = n * C;
        ed.st = st;
        q_d.push_back(ed);
        fork
            begin
                if (hold) begin
                    step();
                    step();
                    cfg_num_vec = 16'(n + 3);
                    cfg_reload_w = !rl;
                    wait_done();
                    start = 1'b0;
                end else begin
                    step();
                    start = 1'b0;
                end
            end
            drive_iact(n);
            drive_oacts(n);
        join
        wait_idle();
    endtask

    task automatic clr_dly();
        for (int i = 0; i < 8; i++) begin
            dly_i[i] = 0;
            dly_o[i] = 0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        clr_dly();
        repeat (3) step();
        chk("rst_func", func, FUNC_IDLE);
        chk("rst_iact_ready", iact_ready, 0);
        chk("rst_oacts_valid", oacts_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_vec_cnt", vec_cnt, 0);
        rstN = 1'b1;
        step();

        do_run(2, 1'b1, 1'b0);
        do_run(1, 1'b0, 1'b0);
        dly_i[1] = 5;
        dly_o[0] = 3;
        dly_o[1] = 3;
        dly_o[2] = 3;
        do_run(3, 1'b1, 1'b0);
        clr_dly();
        do_run(0, 1'b1, 1'b0);

        // Abort in the 8th weight-load cycle.
        cfg_num_vec = 16'd2;
        cfg_reload_w = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        chk("ldw_before_abort", func, FUNC_LOAD_WGHT);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_func", func, FUNC_IDLE);
        wv_m = 1'b0;
        abort = 1'b1;
        start = 1'b1;
        cfg_num_vec = 16'd1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start_idle_busy", busy, 0);
        step();
        cnt_w = 0;
        cnt_i = 0;
        cnt_c = 0;
        do_run(1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of compute.
        cfg_num_vec = 16'd1;
        cfg_reload_w = 1'b0;
        start = 1'b1;
        iact_valid = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (func != FUNC_COMPUTE && k < 200) begin
            step();
            k++;
        end
        chk("reach_compute", func, FUNC_COMPUTE);
        rstN = 1'b0;
        #1;
        chk("midrst_func", func, FUNC_IDLE);
        chk("midrst_busy", busy, 0);
        chk("midrst_iact_ready", iact_ready, 0);
        iact_valid = 1'b0;
        step();
        rstN = 1'b1;
        wv_m = 1'b0;
        cnt_w = 0;
        cnt_i = 0;
        cnt_c = 0;
        step();

        do_run(2, 1'b0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) begin
                dly_i[i] = $urandom_range(0, 4);
                dly_o[i] = $urandom_range(0, 4);
            end
            do_run($urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (5) step();
        chk("sb_oacts_empty", q_o.size(), 0);
        chk("sb_done_empty", q_d.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
